// File: rtl/tx_snap_capture_ctrl_if.sv
// Bus bundle for the TX snapshot capture controller:
// control/data sources in, snapshot BRAM write port and status out.
interface tx_snap_capture_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
);
  logic [31:0]           ctrl_in;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  trig;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_data;
  logic                  bram_we;
  logic [31:0]           status_out;

  modport master (
    output ctrl_in,
    output din,
    output din_valid,
    output trig,
    input  bram_addr,
    input  bram_data,
    input  bram_we,
    input  status_out
  );

  modport slave (
    input  ctrl_in,
    input  din,
    input  din_valid,
    input  trig,
    output bram_addr,
    output bram_data,
    output bram_we,
    output status_out
  );
endinterface

// File: rtl/tx_snap_capture_ctrl.sv
// 10GbE TX snapshot capture sequencer: decodes the PPC control word,
// writes TX words into the snapshot BRAM and reports done/busy/count.
module tx_snap_capture_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
) (
  input  logic                   user_clk,
  input  logic                   user_rst,
  tx_snap_capture_ctrl_if.slave  bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_ctrl_q;
  logic [2:0]            r_ctrl_prev;
  logic                  r_primed;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_we;
  logic                  w_arm_edge;
  logic                  w_wq;
  logic [31:0]           w_status_nxt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [31:0]           r_status;
  logic                  w_unused;

  assign w_unused = ^bus.ctrl_in[31:3];

  // arm must be seen low after reset before a rising edge counts,
  // so an arm bit held high across reset cannot restart a capture
  assign w_arm_edge = r_ctrl_q[0] & ~r_ctrl_prev[0] & r_primed;
  assign w_wq       = r_ctrl_q[2] ? bus.din_valid : 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    if (w_arm_edge) begin
      w_cnt_nxt   = '0;
      w_state_nxt = r_ctrl_q[1] ? S_WAIT : S_CAP;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (bus.trig) begin
            w_state_nxt = S_CAP;
            w_we        = w_wq;
          end
        end
        S_CAP:   w_we = w_wq;
        default: w_we = 1'b0;
      endcase
    end
    if (w_we) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        w_state_nxt = S_DONE;
      end
    end
  end

  always_comb begin
    w_status_nxt           = '0;
    w_status_nxt[31]       = (w_state_nxt == S_DONE);
    w_status_nxt[30]       = (w_state_nxt == S_WAIT) ||
                             (w_state_nxt == S_CAP);
    w_status_nxt[CW-1:0]   = w_cnt_nxt;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state     <= S_IDLE;
      r_ctrl_q    <= '0;
      r_ctrl_prev <= '0;
      r_primed    <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_status    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ctrl_q    <= bus.ctrl_in[2:0];
      r_ctrl_prev <= r_ctrl_q;
      if (!bus.ctrl_in[0]) begin
        r_primed <= 1'b1;
      end
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we;
      if (w_we) begin
        r_addr <= r_cnt[ADDR_WIDTH-1:0];
        r_data <= bus.din;
      end
      r_status    <= w_status_nxt;
    end
  end

  assign bus.bram_we    = r_we;
  assign bus.bram_addr  = r_addr;
  assign bus.bram_data  = r_data;
  assign bus.status_out = r_status;

endmodule

// File: doc/tx_snap_capture_ctrl.md
Name: tx_snap_capture_ctrl

Overview:
- Downstream consumer of the 32-bit software control register for the 10GbE TX snapshot, running in the user_clk domain.
- Decodes arm, trigger-select and write-qualify bits from that register.
- Sequences capture of 64-bit 10GbE TX words into a snapshot BRAM.
- Returns a done/busy/word-count status word for the PPC readback register.

Parameters:
ADDR_WIDTH, 11, BRAM address width; capture depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 64, captured data width; matches the 10GbE TX data bus.

Ports:
user_clk  in  1  user clock; all logic is synchronous to its rising edge.
user_rst  in  1  synchronous active-high reset.
ctrl_in  in  32  control word from the PPC-written register. [0] arm, [1] trig_sel, [2] we_sel; other bits ignored.
din  in  DATA_WIDTH  TX data to capture.
din_valid  in  1  TX data valid.
trig  in  1  external trigger; sampled on the same cycle as din.
bram_addr  out  ADDR_WIDTH  snapshot BRAM write address.
bram_data  out  DATA_WIDTH  snapshot BRAM write data.
bram_we  out  1  snapshot BRAM write enable.
status_out  out  32  [31] done, [30] busy, [ADDR_WIDTH:0] words written, other bits 0.

Behaviour:
- Reset (user_rst=1 at a clock edge): state IDLE; ctrl_q=0; ctrl_prev=0; word count=0. All outputs 0: bram_addr, bram_data, bram_we, status_out. Reset overrides everything, including mid-capture; no further writes are issued after the reset cycle.
- Control input: ctrl_in is registered once into ctrl_q, then delayed once more into ctrl_prev.
  - arm_edge = ctrl_q[0] & ~ctrl_prev[0].
  - Only a 0->1 transition of arm starts a capture. Holding arm high does nothing further.
- Write qualifier: wq = we_sel ? din_valid : 1. trig_sel and we_sel are taken from ctrl_q on every cycle.
- States:
  - IDLE: on arm_edge, clear count and done. If trig_sel=0 go to CAPTURE, else go to WAIT_TRIG.
  - WAIT_TRIG: when trig=1, go to CAPTURE. If wq=1 on that same cycle, the trigger-cycle sample is written as word 0. trig while wq=0 still enters CAPTURE, with nothing written on that cycle.
  - CAPTURE: each cycle with wq=1 writes din at address = count, then count increments. The write with count = 2**ADDR_WIDTH-1 is the last one: go to DONE and set count = 2**ADDR_WIDTH (no wrap).
  - DONE: hold count and done=1. No writes. Only arm_edge leaves this state, restarting as from IDLE.
- arm_edge in WAIT_TRIG or CAPTURE restarts the capture: count=0, re-evaluate trig_sel, and no write on that cycle.
- arm_edge takes priority over trig and over a write on the same cycle.
- Write pipeline: bram_we, bram_addr and bram_data are registered. They appear one cycle after the din/din_valid/trig sample that produced the write.
  - bram_addr equals the count value before the increment.
  - When bram_we=0, bram_addr and bram_data hold their previous values.
- Status, registered with the same one-cycle latency as the write pipeline:
  - status_out[31] = (state==DONE).
  - status_out[30] = (state==WAIT_TRIG or CAPTURE).
  - status_out[ADDR_WIDTH:0] = count.
  - Overall latency from a ctrl_in change to the first state effect is 2 cycles (register + edge detect). The first possible bram_we is at cycle 3 after ctrl_in rises.
- Arithmetic: count is ADDR_WIDTH+1 bits, unsigned, saturating at 2**ADDR_WIDTH.

Test Plan:
1. ADDR_WIDTH=4, trig_sel=0, we_sel=0, din = incrementing 0x1000+n. Arm 0->1 -> exactly 16 bram_we pulses at addr 0..15, each carrying consecutive din values; status_out = 0x80000010 at the end; no further writes while arm stays high.
2. trig_sel=1, trig pulsed 5 cycles after arm, din_valid=1 -> status busy=1 and count=0 while waiting. The word at the trig cycle lands at addr 0; done reached after 16 writes.
3. we_sel=1, din_valid toggling 1,0,1,0 -> writes only on valid cycles; addresses contiguous 0..15; 32 capture cycles to DONE.
4. Arm edge after 7 writes in CAPTURE -> next write is at addr 0, count restarts, done stays 0 until 16 new writes complete.
5. Assert user_rst for 1 cycle mid-capture (count=9) -> status_out=0 and bram_we=0 from the next cycle. The state stays IDLE even though arm is held high, until arm goes 0 then 1.
6. trig and arm_edge on the same cycle in WAIT_TRIG -> restart takes priority: no write, still waiting for trig; a later trig starts capture at addr 0.
